// File: rtl/alu_fwd_unit_pkg.sv
// Shared definitions for the ALU operand forwarding unit: source-select codes,
// the history record layout and the select-code width helper.
package fwd_pkg;

  // fwd_sel codes: register file, live write-back, then history entry k at BASE+k
  localparam int unsigned SEL_RF        = 0;
  localparam int unsigned SEL_WB        = 1;
  localparam int unsigned SEL_HIST_BASE = 2;

  // Record layout at the default widths; parametrised instances keep the same
  // field order in per-field arrays.
  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefAddrW = 5;

  typedef struct packed {
    logic                valid;
    logic [DefAddrW-1:0] addr;
    logic [DefDataW-1:0] data;
  } hist_entry_t;

  // One code for the register file, one for live write-back, one per entry.
  function automatic int unsigned sel_width(input int unsigned depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/alu_fwd_unit_if.sv
// Operand/write-back bundle between the read stage and the forwarding unit.
interface alu_fwd_unit_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned CNT_W   = 16
) ();
  import fwd_pkg::*;

  localparam int unsigned SEL_W = sel_width(DEPTH);

  logic [NUM_SRC*ADDR_W-1:0] src_addr;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic                      wb_en;
  logic [ADDR_W-1:0]         wb_addr;
  logic [DATA_W-1:0]         wb_data;
  logic                      stall;
  logic                      flush;
  logic [NUM_SRC*DATA_W-1:0] op_out;
  logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
  logic [CNT_W-1:0]          hit_cnt;

  modport master (
    output src_addr, src_data, wb_en, wb_addr, wb_data, stall, flush,
    input  op_out, fwd_sel, hit_cnt
  );

  modport slave (
    input  src_addr, src_data, wb_en, wb_addr, wb_data, stall, flush,
    output op_out, fwd_sel, hit_cnt
  );

endinterface

// File: rtl/alu_fwd_unit_select.sv
// Per-operand priority compare-and-mux: live write-back first, then history
// entries youngest to oldest, else register-file data. Address 0 never matches.
module fwd_select
  import fwd_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned SEL_W  = 2
) (
  input  logic [ADDR_W-1:0]             src_addr,
  input  logic [DATA_W-1:0]             src_data,
  input  logic                          wb_en,
  input  logic [ADDR_W-1:0]             wb_addr,
  input  logic [DATA_W-1:0]             wb_data,
  input  logic [DEPTH-1:0]              hist_valid,
  input  logic [DEPTH-1:0][ADDR_W-1:0]  hist_addr,
  input  logic [DEPTH-1:0][DATA_W-1:0]  hist_data,
  output logic [DATA_W-1:0]             op_out,
  output logic [SEL_W-1:0]              fwd_sel
);

  // Scan oldest to youngest so the youngest match is the last write; live wb overrides all.
  always_comb begin
    op_out  = src_data;
    fwd_sel = SEL_W'(SEL_RF);
    if (src_addr != '0) begin
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
        if (hist_valid[k] && (hist_addr[k] == src_addr)) begin
          op_out  = hist_data[k];
          fwd_sel = SEL_W'(SEL_HIST_BASE + unsigned'(k));
        end
      end
      if (wb_en && (wb_addr == src_addr)) begin
        op_out  = wb_data;
        fwd_sel = SEL_W'(SEL_WB);
      end
    end
  end

endmodule

// File: rtl/alu_fwd_unit.sv
// Operand forwarding unit: owns the write-back history shift register and the
// forward-hit counter, and fans out one selector per ALU source operand.
module alu_fwd_unit
  import fwd_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned CNT_W   = 16
) (
  input logic          Clock,
  input logic          Resetn,
  alu_fwd_unit_if.slave bus
);

  localparam int unsigned SEL_W = sel_width(DEPTH);

  logic [DEPTH-1:0]             hist_valid_q, hist_valid_d;
  logic [DEPTH-1:0][ADDR_W-1:0] hist_addr_q, hist_addr_d;
  logic [DEPTH-1:0][DATA_W-1:0] hist_data_q, hist_data_d;
  logic [CNT_W-1:0]             hit_cnt_q, hit_cnt_d;

  logic [DATA_W-1:0]         op_arr  [NUM_SRC];
  logic [SEL_W-1:0]          sel_arr [NUM_SRC];
  logic [NUM_SRC*DATA_W-1:0] op_flat;
  logic [NUM_SRC*SEL_W-1:0]  sel_flat;
  logic                      any_fwd;

  // History next state: flush clears valids, stall holds, otherwise push wb at h[0].
  always_comb begin
    hist_valid_d = hist_valid_q;
    hist_addr_d  = hist_addr_q;
    hist_data_d  = hist_data_q;
    if (bus.flush) begin
      hist_valid_d = '0;
    end else if (!bus.stall) begin
      hist_valid_d[0] = bus.wb_en && (bus.wb_addr != '0);
      hist_addr_d[0]  = bus.wb_addr;
      hist_data_d[0]  = bus.wb_data;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        hist_valid_d[k] = hist_valid_q[k-1];
        hist_addr_d[k]  = hist_addr_q[k-1];
        hist_data_d[k]  = hist_data_q[k-1];
      end
    end
  end

  // History register.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      hist_valid_q <= '0;
      hist_addr_q  <= '0;
      hist_data_q  <= '0;
    end else begin
      hist_valid_q <= hist_valid_d;
      hist_addr_q  <= hist_addr_d;
      hist_data_q  <= hist_data_d;
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_select #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH),
      .SEL_W  (SEL_W)
    ) u_fwd_select (
      .src_addr   (bus.src_addr[i*ADDR_W +: ADDR_W]),
      .src_data   (bus.src_data[i*DATA_W +: DATA_W]),
      .wb_en      (bus.wb_en),
      .wb_addr    (bus.wb_addr),
      .wb_data    (bus.wb_data),
      .hist_valid (hist_valid_q),
      .hist_addr  (hist_addr_q),
      .hist_data  (hist_data_q),
      .op_out     (op_arr[i]),
      .fwd_sel    (sel_arr[i])
    );
  end

  // Pack per-operand results and flag any operand that was bypassed.
  always_comb begin
    op_flat  = '0;
    sel_flat = '0;
    any_fwd  = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      op_flat[i*DATA_W +: DATA_W] = op_arr[i];
      sel_flat[i*SEL_W +: SEL_W]  = sel_arr[i];
      if (sel_arr[i] != SEL_W'(SEL_RF)) any_fwd = 1'b1;
    end
  end

  // Hit counter next state: count unstalled forwarding cycles, stick at all-ones.
  always_comb begin
    hit_cnt_d = hit_cnt_q;
    if (!bus.stall && any_fwd && (hit_cnt_q != {CNT_W{1'b1}})) begin
      hit_cnt_d = hit_cnt_q + CNT_W'(1);
    end
  end

  // Hit counter register.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) hit_cnt_q <= '0;
    else         hit_cnt_q <= hit_cnt_d;
  end

  assign bus.op_out  = op_flat;
  assign bus.fwd_sel = sel_flat;
  assign bus.hit_cnt = hit_cnt_q;

endmodule

// File: doc/alu_fwd_unit.md
# alu_fwd_unit

Parametrised operand forwarding unit in front of the ALU. It keeps a short history of retired write-back results and bypasses them onto any number of ALU source operands. This removes read-after-write hazards when register-file read data is stale. It sits between the register-file read stage and the ALU inputs, and generalises the two-operand, one-deep write-back bypass to NUM_SRC operands and DEPTH history entries with address-compare selection, flush, and a hit counter.

## Interface
- DATA_W, 32, operand and write-back data width
- ADDR_W, 5, register address width; address 0 is hard-zero and never forwarded
- NUM_SRC, 2, number of ALU source operands
- DEPTH, 2, registered write-back history entries (1..8)
- CNT_W, 16, forward-hit counter width
- Clock  in  1  system clock, rising edge
- Resetn  in  1  reset, asynchronous, active-low
- src_addr  in  NUM_SRC*ADDR_W  source register addresses, operand i at [i*ADDR_W +: ADDR_W]
- src_data  in  NUM_SRC*DATA_W  register-file read data, same packing
- wb_en  in  1  write-back valid this cycle
- wb_addr  in  ADDR_W  write-back destination
- wb_data  in  DATA_W  write-back result
- stall  in  1  pipeline frozen; history holds
- flush  in  1  invalidate all history entries
- op_out  out  NUM_SRC*DATA_W  forwarded operands to ALU
- fwd_sel  out  NUM_SRC*SEL_W  per-operand source code, SEL_W = clog2(DEPTH+2)
- hit_cnt  out  CNT_W  saturating count of cycles with at least one forward, stall=0

## Operation
- History: entries h[0] (youngest) .. h[DEPTH-1], each {valid, addr, data}.
- When stall=0 and flush=0: h[0] <= {wb_en && wb_addr!=0, wb_addr, wb_data}; h[k] <= h[k-1].
- When stall=1 and flush=0: history holds.
- flush=1: all valid bits cleared next edge. flush overrides stall and the push; the current wb is discarded from history.
- Selection per operand i, youngest match wins:
  - live wb (wb_en, wb_addr==src_addr_i, src_addr_i!=0) -> code 1
  - else first valid h[k] with addr match -> code k+2
  - else src_data_i -> code 0
- Same address in several entries: the youngest entry is used.
- src_addr_i==0: always code 0 with op_out = src_data_i unchanged.
- hit_cnt increments by 1 on an edge where stall=0 and any fwd_sel!=0. It saturates at all-ones and does not wrap.

## Timing
- op_out and fwd_sel are combinational from inputs and history, with zero latency.
- A wb seen at edge n is available as h[0] from cycle n+1 and is forwarded through cycle n+DEPTH (absent stall). After that the register file holds it.
- Reset (asynchronous, Resetn=0): all valid bits 0, addr and data 0, hit_cnt 0. op_out then equals src_data and fwd_sel equals 0, regardless of Clock.
- Reset mid-stream: history is lost immediately. The first edge after Resetn rises behaves as a normal push.
- Simultaneous stall and wb_en: live wb is still forwarded combinationally, but not pushed. Upstream guarantees the wb repeats or the regfile is written.

## Structure
- A shared package fwd_pkg holds:
  - fwd_sel code localparams: SEL_RF=0, SEL_WB=1, SEL_HIST_BASE=2
  - the hist_entry_t {valid, addr, data} typedef
  - function sel_width(DEPTH)
- One sub-module, fwd_select, per operand and instantiated NUM_SRC times in a generate loop. It is the priority compare-and-mux over live wb plus DEPTH entries. The top level owns the history shift register and hit counter.

## Test plan
- Reset and no-match: Resetn=0, then src_addr={3,4}, src_data={0xA,0xB}, wb_en=0 -> op_out={0xA,0xB}, fwd_sel={0,0}, hit_cnt=0.
- Live bypass: wb_en=1, wb_addr=3, wb_data=0x1234, src_addr={3,3} -> both operands 0x1234, fwd_sel=1. Next cycle with wb_en=0 -> fwd_sel=2, data 0x1234.
- Priority across ages (DEPTH=2):
  - writes r5=0x11 at cycle 0, r5=0x22 at cycle 1, src_addr=5 at cycle 2 -> 0x22, code 2
  - at cycle 3 -> 0x22, code 3
  - at cycle 4 -> src_data, code 0
- Register zero: wb_en=1, wb_addr=0, wb_data=0xFFFF, src_addr=0, src_data=0 -> op_out=0, code 0, nothing pushed.
- Stall and flush:
  - stall=1 for 3 cycles after write r7=0x55 -> h[0] retains r7, forwarded with code 2 throughout
  - flush=1 with stall=1 -> next cycle code 0
- Counter saturation: CNT_W=4, 20 consecutive forwarding cycles -> hit_cnt=15 and holds. Asynchronous reset mid-run -> 0 without a clock edge.
